// File: rtl/aes_key_schedule.sv
`default_nettype none
// ============================================================================
// Module   : aes_key_schedule
// Brief    : Iterative AES-128 key expansion into an 11x128 round-key file,
//            followed by forward/reverse round-key streaming per Start.
// Revision : 1.0 - initial release
// ============================================================================
`ifndef AES_BLOCK_SIZE
`define AES_BLOCK_SIZE 128
`endif

module aes_key_schedule #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic                       Clk,
  input  logic                       Rst_n,
  input  logic                       Key_valid,
  output logic                       Key_ready,
  input  logic [`AES_BLOCK_SIZE-1:0] Key,
  output logic                       Key_loaded,
  input  logic                       Start_valid,
  output logic                       Start_ready,
  input  logic                       Encrypt,
  output logic                       Round_key_valid,
  input  logic                       Round_key_ready,
  output logic [`AES_BLOCK_SIZE-1:0] Round_key,
  output logic [3:0]                 Round_key_idx,
  output logic                       Round_key_last
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_EXPAND = 2'd1;
  localparam logic [1:0] ST_READY  = 2'd2;
  localparam logic [1:0] ST_STREAM = 2'd3;

  localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS);
  // Counter value meaning "rk[NUM_ROUNDS] has been written"
  localparam logic [3:0] DONE_CNT = 4'(NUM_ROUNDS + 1);

  logic [1:0]   state;
  logic [1:0]   state_nxt;
  logic [127:0] rk [0:NUM_ROUNDS];
  logic [127:0] cur_key;
  logic [127:0] next_key;
  logic [3:0]   round_cnt;
  logic [3:0]   idx;
  logic         enc_latched;
  logic         key_hs;
  logic         start_hs;
  logic         rk_hs;
  logic         stream_last;
  logic         expand_en;
  logic [31:0]  rot_word;
  logic [31:0]  sub_word;
  logic [31:0]  temp;
  logic [31:0]  nw0, nw1, nw2, nw3;
  logic [7:0]   rcon;

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Forward S-box: multiplicative inverse (x^254, maps 0 to 0) then affine map
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  assign key_hs      = Key_valid & Key_ready;
  assign start_hs    = Start_valid & Start_ready;
  assign rk_hs       = Round_key_valid & Round_key_ready;
  assign stream_last = enc_latched ? (idx == LAST_IDX) : (idx == 4'd0);
  assign expand_en   = (state == ST_EXPAND) && (round_cnt != DONE_CNT);

  // Key expansion step: derive the next round key from the previous one
  assign rot_word = {cur_key[23:0], cur_key[31:24]};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_sbox
      assign sub_word[gi*8 +: 8] = sbox(rot_word[gi*8 +: 8]);
    end
  endgenerate

  // Round constant for the key currently being produced
  always_comb begin
    rcon = 8'h00;
    case (round_cnt)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  assign temp     = sub_word ^ {rcon, 24'h000000};
  assign nw0      = cur_key[127:96] ^ temp;
  assign nw1      = cur_key[95:64]  ^ nw0;
  assign nw2      = cur_key[63:32]  ^ nw1;
  assign nw3      = cur_key[31:0]   ^ nw2;
  assign next_key = {nw0, nw1, nw2, nw3};

  // State register
  always_ff @(posedge Clk) begin
    if (!Rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode; a key load in READY takes priority over Start
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (key_hs) state_nxt = ST_EXPAND;
      ST_EXPAND: if (round_cnt == DONE_CNT) state_nxt = ST_READY;
      ST_READY: begin
        if (key_hs)        state_nxt = ST_EXPAND;
        else if (start_hs) state_nxt = ST_STREAM;
      end
      ST_STREAM: if (rk_hs && stream_last) state_nxt = ST_READY;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Output decode from state and registered stream pointer
  always_comb begin
    Key_ready       = Rst_n & ((state == ST_IDLE) | (state == ST_READY));
    Start_ready     = Rst_n & (state == ST_READY) & ~Key_valid;
    Key_loaded      = (state == ST_READY) | (state == ST_STREAM);
    Round_key_valid = (state == ST_STREAM);
    Round_key       = '0;
    Round_key_idx   = 4'd0;
    Round_key_last  = 1'b0;
    if (state == ST_STREAM) begin
      Round_key      = rk[idx];
      Round_key_idx  = idx;
      Round_key_last = stream_last;
    end
  end

  // Expansion counter, stream direction and stream index
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      round_cnt   <= 4'd0;
      idx         <= 4'd0;
      enc_latched <= 1'b0;
    end else begin
      if (key_hs)         round_cnt <= 4'd1;
      else if (expand_en) round_cnt <= round_cnt + 4'd1;

      if (start_hs) begin
        enc_latched <= Encrypt;
        idx         <= Encrypt ? 4'd0 : LAST_IDX;
      end else if (rk_hs && !stream_last) begin
        idx <= enc_latched ? (idx + 4'd1) : (idx - 4'd1);
      end
    end
  end

  // Round-key file; contents are meaningless until a full expansion completes
  always_ff @(posedge Clk) begin
    if (key_hs) begin
      rk[0]   <= Key;
      cur_key <= Key;
    end else if (expand_en) begin
      rk[round_cnt] <= next_key;
      cur_key       <= next_key;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_aes_key_schedule.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_key_schedule
// Brief    : Scoreboard bench for aes_key_schedule (load, stream, stalls,
//            priority, reset abort, back-to-back streams).
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_key_schedule;

  logic         Clk = 1'b0;
  logic         Rst_n = 1'b0;
  logic         Key_valid = 1'b0;
  logic         Start_valid = 1'b0;
  logic         Encrypt = 1'b0;
  logic         Round_key_ready = 1'b0;
  logic [127:0] Key = '0;
  logic         Key_ready, Key_loaded, Start_ready, Round_key_valid, Round_key_last;
  logic [127:0] Round_key;
  logic [3:0]   Round_key_idx;

  aes_key_schedule #(.NUM_ROUNDS(10)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .Key_valid(Key_valid), .Key_ready(Key_ready), .Key(Key), .Key_loaded(Key_loaded),
    .Start_valid(Start_valid), .Start_ready(Start_ready), .Encrypt(Encrypt),
    .Round_key_valid(Round_key_valid), .Round_key_ready(Round_key_ready),
    .Round_key(Round_key), .Round_key_idx(Round_key_idx), .Round_key_last(Round_key_last)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [3:0]   idx;
    logic [127:0] key;
    logic         last;
  } exp_t;

  exp_t         sb[$];
  logic [127:0] model_rk [0:10];
  logic [127:0] got [0:10];
  int           checks = 0;
  int           errors = 0;
  int           xfers = 0;
  int           extra = 0;
  int           starts_seen = 0;
  int           cyc = 0;
  int           xfer_cyc[$];
  int           bp_mode = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r, aa, bb;
    r = 8'h00; aa = a; bb = b;
    while (bb != 8'h00) begin
      if (bb[0]) r = r ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
      bb = bb >> 1;
    end
    return r;
  endfunction

  function automatic logic [7:0] m_sbox(input logic [7:0] x);
    logic [7:0] inv, s, c;
    inv = 8'h00;
    c   = 8'h63;
    for (int y = 1; y < 256; y++)
      if (m_mul(x, 8'(y)) == 8'h01) inv = 8'(y);
    for (int i = 0; i < 8; i++)
      s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
    return s;
  endfunction

  task automatic model_expand(input logic [127:0] k);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {m_sbox(t[23:16]), m_sbox(t[15:8]), m_sbox(t[7:0]), m_sbox(t[31:24])} ^ {rc, 24'h0};
        rc = rc[7] ? ((rc << 1) ^ 8'h1b) : (rc << 1);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) model_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic push_stream(input logic enc);
    exp_t e;
    for (int n = 0; n < 11; n++) begin
      e.idx  = enc ? 4'(n) : 4'(10 - n);
      e.key  = model_rk[e.idx];
      e.last = (n == 10);
      sb.push_back(e);
    end
  endtask

  // ---------------- consumer ready driver ----------------
  initial begin
    forever begin
      @(posedge Clk); #1;
      Round_key_ready = (bp_mode != 0) ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
  end

  // ---------------- monitor / scoreboard pop ----------------
  logic         held_valid = 1'b0;
  logic [127:0] held_key;
  logic [3:0]   held_idx;
  logic         held_last;
  exp_t         e_mon;

  always @(negedge Clk) begin
    cyc++;
    if (Rst_n) begin
      if (Start_valid && Start_ready) starts_seen++;
      if (held_valid) begin
        chk("stall_valid", Round_key_valid, 1);
        chk("stall_key", Round_key, held_key);
        chk("stall_idx", Round_key_idx, held_idx);
        chk("stall_last", Round_key_last, held_last);
      end
      if (Round_key_valid && Round_key_ready) begin
        xfers++;
        xfer_cyc.push_back(cyc);
        if (Round_key_idx <= 4'd10) got[Round_key_idx] = Round_key;
        if (sb.size() == 0) begin
          extra++;
        end else begin
          e_mon = sb.pop_front();
          chk("rk_idx", Round_key_idx, e_mon.idx);
          chk("rk_key", Round_key, e_mon.key);
          chk("rk_last", Round_key_last, e_mon.last);
        end
      end
      held_valid = Round_key_valid && !Round_key_ready;
      held_key   = Round_key;
      held_idx   = Round_key_idx;
      held_last  = Round_key_last;
    end else begin
      held_valid = 1'b0;
    end
  end

  // ---------------- stimulus tasks ----------------
  task automatic load_key(input logic [127:0] k, input logic hold_start);
    int n;
    chk("key_ready_pre", Key_ready, 1);
    Key = k; Key_valid = 1'b1; Encrypt = 1'b1;
    if (hold_start) Start_valid = 1'b1;
    #1;
    chk("start_ready_with_key", Start_ready, 0);
    @(posedge Clk); #1;
    Key_valid = 1'b0;
    model_expand(k);
    n = 0;
    while (!Key_loaded && n < 40) begin
      if (hold_start) chk("start_ready_expand", Start_ready, 0);
      chk("valid_expand", Round_key_valid, 0);
      @(posedge Clk); #1;
      n++;
    end
    Start_valid = 1'b0;
    chk("load_latency", n, 11);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 400) begin
      @(posedge Clk); #1;
      n++;
    end
    chk("drain_left", sb.size(), 0);
    sb.delete();
    chk("valid_after_last", Round_key_valid, 0);
    chk("start_ready_back", Start_ready, 1);
  endtask

  task automatic run_stream(input logic enc);
    int x0;
    x0 = xfers;
    chk("start_ready", Start_ready, 1);
    push_stream(enc);
    Start_valid = 1'b1; Encrypt = enc;
    @(posedge Clk); #1;
    Start_valid = 1'b0;
    wait_drain();
    chk("xfer_count", xfers - x0, 11);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n, s0, x0, c0;

    // Reset values
    Rst_n = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_key_ready", Key_ready, 0);
    chk("rst_key_loaded", Key_loaded, 0);
    chk("rst_start_ready", Start_ready, 0);
    chk("rst_valid", Round_key_valid, 0);
    chk("rst_round_key", Round_key, 0);
    chk("rst_idx", Round_key_idx, 0);
    chk("rst_last", Round_key_last, 0);
    Rst_n = 1'b1;
    #1;
    chk("idle_key_ready", Key_ready, 1);

    // Start before any key is loaded is refused
    Start_valid = 1'b1; Encrypt = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge Clk); #1;
      chk("nokey_start_ready", Start_ready, 0);
      chk("nokey_valid", Round_key_valid, 0);
    end
    Start_valid = 1'b0;

    // FIPS-197 key, Start held during expansion
    load_key(128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b1);
    for (int i = 0; i < 11; i++) got[i] = '0;
    run_stream(1'b1);
    chk("fips_rk0", got[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);
    chk("fips_rk1", got[1], 128'ha0fafe1788542cb123a339392a6c7605);
    chk("fips_rk10", got[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    run_stream(1'b0);

    // Random backpressure, both directions
    bp_mode = 1;
    run_stream(1'b1);
    run_stream(1'b0);
    bp_mode = 0;
    @(posedge Clk); #1;

    // Key and Start together in READY: key wins
    load_key(128'h000102030405060708090a0b0c0d0e0f, 1'b1);
    for (int i = 0; i < 11; i++) got[i] = '0;
    run_stream(1'b1);
    chk("key2_rk10", got[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);

    // Two back-to-back encrypt streams with Start held high
    s0 = starts_seen; c0 = xfer_cyc.size();
    push_stream(1'b1);
    push_stream(1'b1);
    Start_valid = 1'b1; Encrypt = 1'b1;
    n = 0;
    while ((starts_seen - s0) < 2 && n < 100) begin
      @(posedge Clk); #1;
      n++;
    end
    Start_valid = 1'b0;
    chk("b2b_starts", starts_seen - s0, 2);
    wait_drain();
    chk("b2b_xfers", xfer_cyc.size() - c0, 22);
    if (xfer_cyc.size() - c0 >= 12) begin
      chk("b2b_burst1", xfer_cyc[c0+10] - xfer_cyc[c0], 10);
      chk("b2b_gap", xfer_cyc[c0+11] - xfer_cyc[c0+10], 2);
    end

    // Reset in the middle of a stream
    x0 = xfers;
    push_stream(1'b1);
    Start_valid = 1'b1; Encrypt = 1'b1;
    @(posedge Clk); #1;
    Start_valid = 1'b0;
    n = 0;
    while ((xfers - x0) < 5 && n < 50) begin
      @(posedge Clk); #1;
      n++;
    end
    chk("pre_reset_xfers", xfers - x0, 5);
    Rst_n = 1'b0;
    sb.delete();
    @(posedge Clk); #1;
    chk("abort_valid", Round_key_valid, 0);
    chk("abort_loaded", Key_loaded, 0);
    chk("abort_key_ready_low", Key_ready, 0);
    Rst_n = 1'b1;
    #1;
    chk("abort_key_ready", Key_ready, 1);
    Start_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge Clk); #1;
      chk("abort_start_ready", Start_ready, 0);
      chk("abort_no_stream", Round_key_valid, 0);
    end
    Start_valid = 1'b0;

    // Recovery with a fresh key
    load_key(128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b0);
    run_stream(1'b0);

    repeat (3) @(posedge Clk);
    #1;
    chk("extra_xfers", extra, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
